// File: rtl/bram_sdp_ext_pkg.sv
// Shared defaults and clear-sequencer state type for the extended SDP block RAM.
// No logic, so no latency; parameters only.
package bram_sdp_ext_pkg;

    localparam int BRAM_DEPTH_IN      = 48;
    localparam int LOG2_BRAM_DEPTH_IN = 6;
    localparam int BRAM_RD_LATENCY    = 1;
    localparam int BRAM_WRITE_FIRST   = 1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/bram_sdp_ext_core.sv
// Raw block-RAM array: per-byte write enable, registered read-first read port.
// 1-cycle read latency, no reset and no backpressure; the caller keeps addresses in range.
module bram_sdp_core
    import bram_sdp_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = LOG2_BRAM_DEPTH_IN,
    parameter int DEPTH      = BRAM_DEPTH_IN
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam int NB = DATA_WIDTH / 8;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Read samples the pre-write contents, so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bram_sdp_ext.sv
// SDP RAM wrapper: byte-enable writes, collision bypass, range check, clear sequencer.
// Read latency RD_LATENCY (1 or 2); no backpressure, user ports are ignored while clr_busy_o/clr_done_o.
module bram_sdp_ext
    import bram_sdp_ext_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = LOG2_BRAM_DEPTH_IN,
    parameter int DEPTH       = BRAM_DEPTH_IN,
    parameter int RD_LATENCY  = BRAM_RD_LATENCY,
    parameter int WRITE_FIRST = BRAM_WRITE_FIRST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_data_vld_o,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic                    clr_start_i,
    output logic                    clr_busy_o,
    output logic                    clr_done_o
);

    localparam int                    NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  idle;

    logic                  rd_in_range, wr_in_range;
    logic                  rd_ok, wr_ok, collide;

    logic                  core_we, core_re;
    logic [ADDR_WIDTH-1:0] core_wr_addr;
    logic [NB-1:0]         core_be;
    logic [DATA_WIDTH-1:0] core_wr_data, core_rd_data;

    logic                  s1_vld_q, s1_oob_q, s1_byp_q;
    logic [NB-1:0]         s1_be_q;
    logic [DATA_WIDTH-1:0] s1_wdata_q;
    logic [DATA_WIDTH-1:0] s1_word;

    // Clear sequencer: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear sequencer: next state. The counter stops at the last word, never overflowing.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_start_i) begin
                    state_d    = CLR_CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLR_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = CLR_DONE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    // Clear sequencer: outputs
    always_comb begin
        idle       = (state_q == CLR_IDLE);
        clr_busy_o = (state_q == CLR_CLEAR);
        clr_done_o = (state_q == CLR_DONE);
    end

    assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_L);
    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_L);
    assign rd_ok       = idle && re_i;
    assign wr_ok       = idle && we_i && wr_in_range && (|wr_be_i);
    assign collide     = rd_ok && wr_ok && (rd_addr_i == wr_addr_i);

    // Write port belongs to the clear sequencer while it runs, otherwise to the user.
    always_comb begin
        core_we      = wr_ok;
        core_wr_addr = wr_addr_i;
        core_be      = wr_be_i;
        core_wr_data = wr_data_i;
        if (state_q == CLR_CLEAR) begin
            core_we      = 1'b1;
            core_wr_addr = clr_addr_q;
            core_be      = '1;
            core_wr_data = '0;
        end
    end

    assign core_re = rd_ok && rd_in_range;

    bram_sdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk       (clk),
        .we_i      (core_we),
        .wr_addr_i (core_wr_addr),
        .wr_be_i   (core_be),
        .wr_data_i (core_wr_data),
        .re_i      (core_re),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (core_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_oob_q <= 1'b0;
            s1_byp_q <= 1'b0;
        end else begin
            s1_vld_q <= rd_ok;
            s1_oob_q <= rd_ok && !rd_in_range;
            s1_byp_q <= collide && (WRITE_FIRST != 0);
        end
    end

    // Bypass payload is only consumed when s1_byp_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (collide) begin
            s1_be_q    <= wr_be_i;
            s1_wdata_q <= wr_data_i;
        end
    end

    always_comb begin
        s1_word = core_rd_data;
        if (s1_byp_q) begin
            for (int i = 0; i < NB; i++) begin
                if (s1_be_q[i]) begin
                    s1_word[8*i +: 8] = s1_wdata_q[8*i +: 8];
                end
            end
        end
        if (!s1_vld_q || s1_oob_q) begin
            s1_word = '0;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data_q <= '0;
                s2_vld_q  <= 1'b0;
            end else begin
                s2_data_q <= s1_word;
                s2_vld_q  <= s1_vld_q;
            end
        end

        assign rd_data_o     = s2_data_q;
        assign rd_data_vld_o = s2_vld_q;
    end else begin : g_lat1
        assign rd_data_o     = s1_word;
        assign rd_data_vld_o = s1_vld_q;
    end

endmodule

// File: tb/tb_bram_sdp_ext.sv
// Bench for bram_sdp_ext: two instances (latency 1 write-first, latency 2 read-first) share stimulus
// and are checked every cycle against an array-based reference model.
module tb_bram_sdp_ext;

    localparam int DW    = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 48;
    localparam int NB    = DW / 8;
    localparam int NE    = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          re, we, clr_start;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;

    logic [DW-1:0] rd_a, rd_b;
    logic          vld_a, vld_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    bram_sdp_ext #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1), .WRITE_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .re_i(re), .rd_addr_i(rd_addr), .rd_data_o(rd_a), .rd_data_vld_o(vld_a),
        .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .clr_start_i(clr_start), .clr_busy_o(busy_a), .clr_done_o(done_a)
    );

    bram_sdp_ext #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(2), .WRITE_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .re_i(re), .rd_addr_i(rd_addr), .rd_data_o(rd_b), .rd_data_vld_o(vld_b),
        .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .clr_start_i(clr_start), .clr_busy_o(busy_b), .clr_done_o(done_b)
    );

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_da [NE];
    logic [DW-1:0] exp_db [NE];
    bit            exp_va [NE];
    bit            exp_vb [NE];
    int            e        = 0;
    int            cbeg     = -100000;
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] oldw, input logic [DW-1:0] neww,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = oldw;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = neww[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock: update the model from the inputs presented, then check after the edge.
    task automatic step();
        int            ne;
        bit            idle;
        bit            oob;
        logic [DW-1:0] oldw;
        ne   = e + 1;
        idle = !(ne > cbeg && ne <= cbeg + DEPTH + 1);
        if (idle && re) begin
            oob  = (int'(rd_addr) >= DEPTH);
            oldw = '0;
            if (!oob) oldw = ref_mem[rd_addr];
            exp_va[ne]     = 1'b1;
            exp_vb[ne + 1] = 1'b1;
            exp_da[ne]     = (!oob && we && wr_addr == rd_addr) ? merge(oldw, wr_data, wr_be) : oldw;
            exp_db[ne + 1] = oldw;
        end
        if (idle && we && int'(wr_addr) < DEPTH) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
        if (ne > cbeg && ne <= cbeg + DEPTH) ref_mem[ne - cbeg - 1] = '0;
        if (idle && clr_start) cbeg = ne;
        @(posedge clk);
        e = ne;
        #1;
        chk("rd_data_lat1_wf1", rd_a, exp_da[e]);
        chk("rd_vld_lat1",      DW'(vld_a), DW'(exp_va[e]));
        chk("rd_data_lat2_wf0", rd_b, exp_db[e]);
        chk("rd_vld_lat2",      DW'(vld_b), DW'(exp_vb[e]));
        chk("clr_busy_a",       DW'(busy_a), DW'(e >= cbeg && e <= cbeg + DEPTH - 1));
        chk("clr_done_a",       DW'(done_a), DW'(e == cbeg + DEPTH));
        chk("clr_busy_b",       DW'(busy_b), DW'(e >= cbeg && e <= cbeg + DEPTH - 1));
        chk("clr_done_b",       DW'(done_b), DW'(e == cbeg + DEPTH));
    endtask

    task automatic drive(input bit r, input int ra, input bit w, input int wa,
                         input logic [DW-1:0] wd, input logic [NB-1:0] be, input bit cs);
        re        = r;
        rd_addr   = AW'(ra);
        we        = w;
        wr_addr   = AW'(wa);
        wr_data   = wd;
        wr_be     = be;
        clr_start = cs;
        step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic fill_nonzero();
        for (int a = 0; a < DEPTH; a++) drive(0, 0, 1, a, rnd_word() | DW'(1), '1, 0);
    endtask

    initial begin
        for (int i = 0; i < NE; i++) begin
            exp_da[i] = '0; exp_db[i] = '0; exp_va[i] = 1'b0; exp_vb[i] = 1'b0;
        end
        rst_n = 1'b0; re = 1'b0; we = 1'b0; clr_start = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        #2;
        chk("reset_rd_a",   rd_a, '0);
        chk("reset_vld_a",  DW'(vld_a), '0);
        chk("reset_rd_b",   rd_b, '0);
        chk("reset_vld_b",  DW'(vld_b), '0);
        chk("reset_busy",   DW'(busy_a), '0);
        chk("reset_done",   DW'(done_a), '0);
        rst_n = 1'b1;

        // Bring the array to a known all-zero state.
        drive(0, 0, 0, 0, '0, '0, 1);
        idle_cycles(DEPTH + 1);

        // Full-word write and read-back at both latencies.
        drive(0, 0, 1, 3, {NB{8'hA5}}, '1, 0);
        drive(1, 3, 0, 0, '0, '0, 0);
        idle_cycles(3);

        // Single-byte enable into a zero word.
        drive(0, 0, 1, 5, {NB{8'hFF}}, NB'(1), 0);
        drive(1, 5, 0, 0, '0, '0, 0);
        idle_cycles(3);

        // Same-address read/write collision, then a plain read of the result.
        drive(0, 0, 1, 7, {NB{8'h11}}, '1, 0);
        drive(1, 7, 1, 7, {NB{8'h22}}, '1, 0);
        drive(1, 7, 0, 0, '0, '0, 0);
        idle_cycles(3);

        // Clear with traffic: start alongside a read, hammer the ports while busy, then read all.
        fill_nonzero();
        drive(1, 2, 0, 0, '0, '0, 1);
        for (int i = 0; i < DEPTH + 1; i++)
            drive(1, $urandom_range(0, DEPTH - 1), 1, $urandom_range(0, DEPTH - 1), rnd_word(), '1, 1);
        for (int a = 0; a < DEPTH; a++) drive(1, a, 0, 0, '0, '0, 0);
        idle_cycles(3);

        // Streaming reads on consecutive addresses, then one beyond the array.
        for (int i = 0; i < 16; i++) drive(0, 0, 1, 10 + i, rnd_word(), '1, 0);
        for (int i = 0; i < 16; i++) drive(1, 10 + i, 0, 0, '0, '0, 0);
        drive(1, DEPTH, 1, DEPTH, rnd_word(), '1, 0);
        drive(1, DEPTH, 0, 0, '0, '0, 0);
        idle_cycles(3);

        // Reset half-way through a clear.
        fill_nonzero();
        drive(1, DEPTH - 1, 0, 0, '0, '0, 1);
        while (e < cbeg + DEPTH / 2) idle_cycles(1);
        #1 rst_n = 1'b0;
        #1;
        chk("midclr_busy_a", DW'(busy_a), '0);
        chk("midclr_done_a", DW'(done_a), '0);
        chk("midclr_busy_b", DW'(busy_b), '0);
        chk("midclr_done_b", DW'(done_b), '0);
        chk("midclr_vld_b",  DW'(vld_b), '0);
        chk("midclr_rd_b",   rd_b, '0);
        for (int i = e + 1; i < NE; i++) begin
            exp_da[i] = '0; exp_db[i] = '0; exp_va[i] = 1'b0; exp_vb[i] = 1'b0;
        end
        cbeg = -100000;
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 0, '0, '0, 0);
        drive(1, DEPTH - 1, 0, 0, '0, '0, 0);
        idle_cycles(3);

        // Random traffic including out-of-range addresses, collisions and occasional clears.
        for (int i = 0; i < 400; i++) begin
            int ra, wa;
            ra = $urandom_range(0, 63);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 63);
            drive($urandom_range(0, 1), ra, $urandom_range(0, 1), wa, rnd_word(),
                  NB'($urandom), ($urandom_range(0, 79) == 0));
        end
        idle_cycles(DEPTH + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
